// File: rtl/ym2610_pkg.sv
// Shared types and constants for the YM2610 ADPCM-A ROM bus master.
package ym2610_pkg;

    localparam int ADDR_W = 24;

    // LSB positions of the address fields carried in each multiplex phase
    localparam int LO_RAD = 0;
    localparam int LO_RAL = 8;
    localparam int HI_RAD = 10;
    localparam int HI_RAL = 18;
    localparam int HI_RAU = 20;

    typedef enum logic [2:0] {
        IDLE,
        A_LO,
        MPX_H,
        A_HI,
        MPX_L,
        RD,
        TURN
    } state_e;

endpackage

// File: rtl/ym_phase_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module ym_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ym2610_adpcma_rom_master.sv
// ADPCM-A sample ROM initiator: multiplexed address out on RAD/RA, byte read back on RAD.
module ym2610_adpcma_rom_master
    import ym2610_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int OE_CYC    = 3
) (
    input  logic              CLK_8M,
    input  logic              RESET,
    input  logic              REQ,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [7:0]        LEN,
    output logic              READY,
    output logic [7:0]        DATA,
    output logic              DATA_VALID,
    output logic              DONE,
    output logic [7:0]        RAD_OUT,
    output logic              RAD_OE,
    input  logic [7:0]        RAD_IN,
    output logic [1:0]        RA_L,
    output logic [3:0]        RA_U,
    output logic              RMPX,
    output logic              nSDROE
);

    // Timer holds N-1 so terminal count lands on the last cycle of the phase
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] OE_LD    = 8'(OE_CYC - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [7:0]        rem_q;
    logic [7:0]        data_q;
    logic [3:0]        ra_u_q;
    logic              tmr_load;
    logic [7:0]        tmr_val;
    logic              tmr_tc;

    ym_phase_timer #(.W(8)) u_timer (
        .clk_i      (CLK_8M),
        .rst_i      (RESET),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_ff @(posedge CLK_8M) begin
        if (RESET) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            ra_u_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && REQ) begin
                cur_addr_q <= ADDR;
                rem_q      <= LEN;
            end
            if (state_q == TURN && rem_q != 8'd0) begin
                cur_addr_q <= cur_addr_q + 1'b1;
                rem_q      <= rem_q - 1'b1;
            end
            if (state_q == RD && tmr_tc) begin
                data_q <= RAD_IN;
            end
            // RA_U is a register so it keeps the last high phase until the next one
            if (state_q == MPX_H) begin
                ra_u_q <= cur_addr_q[HI_RAU +: 4];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_load   = 1'b0;
        tmr_val    = SETUP_LD;
        READY      = 1'b0;
        RMPX       = 1'b0;
        nSDROE     = 1'b1;
        RAD_OE     = 1'b0;
        RAD_OUT    = 8'd0;
        RA_L       = 2'd0;
        DATA_VALID = 1'b0;
        DONE       = 1'b0;
        case (state_q)
            IDLE: begin
                READY = 1'b1;
                if (REQ) begin
                    state_d  = A_LO;
                    tmr_load = 1'b1;
                end
            end
            A_LO: begin
                RAD_OE  = 1'b1;
                RAD_OUT = cur_addr_q[LO_RAD +: 8];
                RA_L    = cur_addr_q[LO_RAL +: 2];
                if (tmr_tc) state_d = MPX_H;
            end
            MPX_H: begin
                RAD_OE   = 1'b1;
                RMPX     = 1'b1;
                RAD_OUT  = cur_addr_q[LO_RAD +: 8];
                RA_L     = cur_addr_q[LO_RAL +: 2];
                state_d  = A_HI;
                tmr_load = 1'b1;
            end
            A_HI: begin
                RAD_OE  = 1'b1;
                RMPX    = 1'b1;
                RAD_OUT = cur_addr_q[HI_RAD +: 8];
                RA_L    = cur_addr_q[HI_RAL +: 2];
                if (tmr_tc) state_d = MPX_L;
            end
            MPX_L: begin
                RAD_OE   = 1'b1;
                RAD_OUT  = cur_addr_q[HI_RAD +: 8];
                RA_L     = cur_addr_q[HI_RAL +: 2];
                state_d  = RD;
                tmr_load = 1'b1;
                tmr_val  = OE_LD;
            end
            RD: begin
                nSDROE = 1'b0;
                if (tmr_tc) state_d = TURN;
            end
            TURN: begin
                DATA_VALID = 1'b1;
                if (rem_q != 8'd0) begin
                    state_d  = A_LO;
                    tmr_load = 1'b1;
                end else begin
                    DONE    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign RA_U = ra_u_q;
    assign DATA = data_q;

endmodule

// File: tb/tb_ym2610_adpcma_rom_master.sv
// Bench for ym2610_adpcma_rom_master: vector table, corner sequences, random scoreboard.
module tb_ym2610_adpcma_rom_master;

    localparam int P = 8;

    logic        clk = 1'b0;
    logic        rst, req;
    logic [23:0] addr;
    logic [7:0]  len;
    logic        ready, dv, done, rad_oe, rmpx, nsdroe;
    logic [7:0]  data, rad_out, rad_in;
    logic [1:0]  ra_l;
    logic [3:0]  ra_u;

    logic        rst2, req2;
    logic [23:0] addr2;
    logic [7:0]  len2;
    logic        ready2, dv2, done2, rad_oe2, rmpx2, nsdroe2;
    logic [7:0]  data2, rad_out2, rad_in2;
    logic [1:0]  ra_l2;
    logic [3:0]  ra_u2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ym2610_adpcma_rom_master u_dut (
        .CLK_8M(clk), .RESET(rst), .REQ(req), .ADDR(addr), .LEN(len),
        .READY(ready), .DATA(data), .DATA_VALID(dv), .DONE(done),
        .RAD_OUT(rad_out), .RAD_OE(rad_oe), .RAD_IN(rad_in),
        .RA_L(ra_l), .RA_U(ra_u), .RMPX(rmpx), .nSDROE(nsdroe)
    );

    ym2610_adpcma_rom_master #(.SETUP_CYC(2), .OE_CYC(5)) u_dut2 (
        .CLK_8M(clk), .RESET(rst2), .REQ(req2), .ADDR(addr2), .LEN(len2),
        .READY(ready2), .DATA(data2), .DATA_VALID(dv2), .DONE(done2),
        .RAD_OUT(rad_out2), .RAD_OE(rad_oe2), .RAD_IN(rad_in2),
        .RA_L(ra_l2), .RA_U(ra_u2), .RMPX(rmpx2), .nSDROE(nsdroe2)
    );

    function automatic logic [7:0] rom(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hD5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Cartridge-side address latches
    logic [9:0]  lat_lo = '0;
    logic [13:0] lat_hi = '0;
    logic        rmpx_prev = 1'b0;
    logic [9:0]  bus_prev = '0;
    logic        rd_prev = 1'b0;
    wire  [23:0] lat_addr = {lat_hi, lat_lo};

    assign rad_in  = (nsdroe === 1'b0)  ? rom(lat_addr) : 8'hEE;
    assign rad_in2 = (nsdroe2 === 1'b0) ? 8'h3C : 8'hEE;

    typedef struct {
        logic [23:0] a;
        logic [7:0]  d;
        int          due;
        logic        last;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (rmpx === 1'b1 && rmpx_prev !== 1'b1) lat_lo = {ra_l, rad_out};
        if (rmpx === 1'b0 && rmpx_prev === 1'b1) lat_hi = {ra_u, ra_l, rad_out};
        if (mon_en) begin
            chk("no_contention", {31'd0, rad_oe & ~nsdroe}, 0);
            if (rd_prev) chk("turnaround", rad_oe, 0);
            if (rmpx !== rmpx_prev) chk("mpx_addr_stable", {ra_l, rad_out}, bus_prev);
            if (exp_q.size() == 0) begin
                chk("spurious_dv", dv, 0);
                chk("spurious_done", done, 0);
            end else if (cyc == exp_q[0].due || dv === 1'b1) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dv_cycle", cyc, e.due);
                chk("dv_present", dv, 1);
                chk("dv_data", data, e.d);
                chk("dv_addr", lat_addr, e.a);
                chk("dv_done", done, e.last);
            end else begin
                chk("done_early", done, 0);
            end
            if (rst === 1'b1) exp_q.delete();
            if (req === 1'b1 && ready === 1'b1 && rst !== 1'b1) begin
                for (int i = 0; i <= int'(len); i++) begin
                    exp_t e;
                    e.a    = addr + 24'(i);
                    e.d    = rom(e.a);
                    e.due  = cyc + P * (i + 1);
                    e.last = (i == int'(len));
                    exp_q.push_back(e);
                end
            end
        end
        rmpx_prev = rmpx;
        bus_prev  = {ra_l, rad_out};
        rd_prev   = (nsdroe === 1'b0);
    end

    typedef struct {
        logic [23:0] a;
        logic [7:0]  lo_rad;
        logic [1:0]  lo_ral;
        logic [7:0]  hi_rad;
        logic [1:0]  hi_ral;
        logic [3:0]  hi_rau;
        logic [7:0]  d;
    } vec_t;
    vec_t vecs[4];

    int          n_dv, dv_k, oe_cnt, w;
    int          dv_cyc[4];
    logic [23:0] dv_adr[4];
    logic [7:0]  dv_dat[4];
    logic        dv_dn[4];
    logic [7:0]  d2;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{24'h123456, 8'h56, 2'd0, 8'h8D, 2'd0, 4'h1, 8'hA5};
        vecs[1] = '{24'hFFFFFF, 8'hFF, 2'd3, 8'hFF, 2'd3, 4'hF, 8'h2A};
        vecs[2] = '{24'h000000, 8'h00, 2'd0, 8'h00, 2'd0, 4'h0, 8'hD5};
        vecs[3] = '{24'hABCDEF, 8'hEF, 2'd1, 8'hF3, 2'd2, 4'hA, 8'h5C};

        rst = 1'b1; req = 1'b0; addr = '0; len = '0;
        rst2 = 1'b1; req2 = 1'b0; addr2 = '0; len2 = '0;
        repeat (3) step();
        rst = 1'b0; rst2 = 1'b0;
        sample();
        chk("rst_ready", ready, 1);
        chk("rst_rmpx", rmpx, 0);
        chk("rst_nsdroe", nsdroe, 1);
        chk("rst_rad_oe", rad_oe, 0);
        chk("rst_bus", {ra_u, ra_l, rad_out}, 0);
        chk("rst_data", data, 0);
        chk("rst_pulses", {dv, done}, 0);
        mon_en = 1'b1;
        step();

        // single reads from the vector table
        for (int v = 0; v < 4; v++) begin
            addr = vecs[v].a; len = 8'd0; req = 1'b1;
            step();
            req = 1'b0;
            for (int k = 1; k <= 9; k++) begin
                sample();
                if (k == 1) begin
                    chk("tbl_busy", ready, 0);
                    chk("tbl_lo_rad", rad_out, vecs[v].lo_rad);
                    chk("tbl_lo_ral", ra_l, vecs[v].lo_ral);
                    chk("tbl_lo_oe", {rad_oe, rmpx}, 2'b10);
                end
                if (k == 3) begin
                    chk("tbl_hi_rad", rad_out, vecs[v].hi_rad);
                    chk("tbl_hi_ral", ra_l, vecs[v].hi_ral);
                    chk("tbl_hi_rau", ra_u, vecs[v].hi_rau);
                    chk("tbl_hi_mpx", rmpx, 1);
                end
                if (k == 7) chk("tbl_dv_early", dv, 0);
                if (k == 8) begin
                    chk("tbl_dv", {dv, done}, 2'b11);
                    chk("tbl_data", data, vecs[v].d);
                    chk("tbl_latch", lat_addr, vecs[v].a);
                end
                if (k == 9) chk("tbl_ready_after", {ready, dv}, 2'b10);
                step();
            end
        end

        // burst across the top of the address space
        addr = 24'hFFFFFF; len = 8'd1; req = 1'b1;
        step();
        req = 1'b0;
        n_dv = 0;
        for (int k = 1; k <= 18; k++) begin
            sample();
            if (dv === 1'b1 && n_dv < 4) begin
                dv_cyc[n_dv] = k; dv_adr[n_dv] = lat_addr;
                dv_dat[n_dv] = data; dv_dn[n_dv] = done;
                n_dv++;
            end
            step();
        end
        chk("burst_count", n_dv, 2);
        chk("burst_cyc0", dv_cyc[0], 8);
        chk("burst_cyc1", dv_cyc[1], 16);
        chk("burst_addr0", dv_adr[0], 24'hFFFFFF);
        chk("burst_addr1", dv_adr[1], 24'h000000);
        chk("burst_data0", dv_dat[0], 8'h2A);
        chk("burst_data1", dv_dat[1], 8'hD5);
        chk("burst_done", {dv_dn[0], dv_dn[1]}, 2'b01);

        // request while busy must be dropped
        addr = 24'h000010; len = 8'd0; req = 1'b1;
        step();
        for (int k = 1; k <= 20; k++) begin
            if (k >= 5 && k <= 8) begin
                req = 1'b1; addr = 24'h000100; len = 8'd0;
            end else begin
                req = 1'b0;
            end
            sample();
            if (k <= 8) chk("busy_ready_low", ready, 0);
            if (k == 9) chk("busy_ready_back", ready, 1);
            if (k == 8) begin
                chk("busy_dv", {dv, done}, 2'b11);
                chk("busy_data", data, 8'hC5);
                chk("busy_addr", lat_addr, 24'h000010);
            end
            if (k > 8) chk("busy_no_second", dv, 0);
            step();
        end

        // reset in the middle of the read strobe
        addr = 24'h00ABCD; len = 8'd3; req = 1'b1;
        step();
        req = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 6) rst = 1'b1;
            if (k == 7) rst = 1'b0;
            sample();
            if (k == 6) chk("mrst_in_rd", nsdroe, 0);
            if (k == 7) begin
                chk("mrst_nsdroe", nsdroe, 1);
                chk("mrst_rmpx", rmpx, 0);
                chk("mrst_rad_oe", rad_oe, 0);
                chk("mrst_ready", ready, 1);
                chk("mrst_data", data, 0);
            end
            if (k >= 6) chk("mrst_no_pulse", {dv, done}, 0);
            step();
        end

        // stretched timing on the second instance
        addr2 = 24'h123456; len2 = 8'd0; req2 = 1'b1;
        step();
        req2 = 1'b0;
        oe_cnt = 0; dv_k = 0; d2 = '0;
        for (int k = 1; k <= 16; k++) begin
            sample();
            if (nsdroe2 === 1'b0) oe_cnt++;
            if (dv2 === 1'b1) begin
                dv_k = k; d2 = data2;
                chk("t2_done", done2, 1);
            end
            if (k == 13) chk("t2_ready", ready2, 1);
            step();
        end
        chk("t2_oe_cycles", oe_cnt, 5);
        chk("t2_dv_cycle", dv_k, 12);
        chk("t2_data", d2, 8'h3C);

        // random traffic against the scoreboard
        for (int n = 0; n < 1000; n++) begin
            w = 0;
            while (ready !== 1'b1 && w < 1200) begin
                req  = 1'($urandom_range(0, 1));
                addr = 24'($urandom);
                len  = 8'($urandom_range(0, 3));
                step();
                w++;
            end
            if (ready !== 1'b1) begin
                chk("rand_ready_timeout", ready, 1);
                break;
            end
            req = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            if ($urandom_range(0, 7) == 0) addr = 24'hFFFFFF - 24'($urandom_range(0, 3));
            else addr = 24'($urandom);
            len = 8'($urandom_range(0, 3));
            req = 1'b1;
            step();
            req = 1'b0;
        end
        w = 0;
        while (ready !== 1'b1 && w < 1200) begin
            step();
            w++;
        end
        repeat (3) step();
        chk("rand_final_ready", ready, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
